// File: rtl/uart_frame_tx_pkg.sv
// Shared UART transmit constants, state encoding and frame builder.
package uart_frame_tx_pkg;

    localparam int FRAME_BITS           = 11;
    localparam int DATA_BITS            = 8;
    localparam logic START_BIT          = 1'b0;
    localparam logic STOP_BIT           = 1'b1;
    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam logic [3:0] LAST_BIT_IDX = 4'd10;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    // Assemble the line image of one frame, bit 0 goes out first.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [DATA_BITS-1:0] data,
        input logic                 odd
    );
        return {STOP_BIT, (^data) ^ odd, data, START_BIT};
    endfunction

endpackage

// File: rtl/uart_frame_tx_baud_gen.sv
// Reloadable baud counter: bit_tick is high on the last cycle of every bit period.
module uart_baud_gen
    import uart_frame_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic bit_tick,
    output logic tick_ahead
);

    localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

    logic [15:0] count;

    // Count down each bit period; bit_tick is registered so it lines up with count==0.
    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            bit_tick <= 1'b0;
        end else if (restart) begin
            count    <= RELOAD;
            bit_tick <= 1'b0;
        end else if (enable) begin
            if (count == 16'd0) begin
                count    <= RELOAD;
                bit_tick <= 1'b0;
            end else begin
                count    <= count - 16'd1;
                bit_tick <= (count == 16'd1);
            end
        end else begin
            bit_tick <= 1'b0;
        end
    end

    // One cycle early warning of bit_tick, lets the parent register frame_done.
    assign tick_ahead = enable && (count == 16'd1);

endmodule

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: start, 8 data bits LSB first, parity, stop.
module uart_frame_tx
    import uart_frame_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    tx_state_t             state;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [3:0]            bit_cnt;
    logic [FRAME_BITS-1:0] new_frame;
    logic                  accept;
    logic                  bit_tick;
    logic                  tick_ahead;

    assign new_frame = build_frame(data_in, PARITY_ODD != 0);
    assign accept    = (state == IDLE) && data_valid && data_ready;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clock      (clock),
        .reset      (reset),
        .restart    (accept),
        .enable     (state == SEND),
        .bit_tick   (bit_tick),
        .tick_ahead (tick_ahead)
    );

    // Frame FSM: load on accept, shift on each bit tick, leave after the stop bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            data_ready <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    tx         <= 1'b1;
                    if (accept) begin
                        shift_reg  <= new_frame;
                        tx         <= new_frame[0];
                        bit_cnt    <= '0;
                        busy       <= 1'b1;
                        data_ready <= 1'b0;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    frame_done <= tick_ahead && (bit_cnt == LAST_BIT_IDX);
                    if (bit_tick) begin
                        if (bit_cnt == LAST_BIT_IDX) begin
                            shift_reg  <= '0;
                            bit_cnt    <= '0;
                            tx         <= 1'b1;
                            busy       <= 1'b0;
                            data_ready <= 1'b1;
                            frame_done <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            shift_reg <= {1'b0, shift_reg[FRAME_BITS-1:1]};
                            tx        <= shift_reg[1];
                            bit_cnt   <= bit_cnt + 4'd1;
                        end
                    end else begin
                        tx <= shift_reg[0];
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx with an even- and an odd-parity instance.
module tb_uart_frame_tx;

    localparam int CPB          = 4;
    localparam int FRAME_CYCLES = 11 * CPB;

    logic       clock = 1'b0;
    logic       reset;
    logic       data_valid;
    logic [7:0] data_in;
    logic       data_ready0, tx0, busy0, frame_done0;
    logic       data_ready1, tx1, busy1, frame_done1;

    int errors = 0;
    int checks = 0;

    // Free-running 10 ns clock.
    always #5 clock = ~clock;

    uart_frame_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) u_even (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready0), .tx(tx0), .busy(busy0), .frame_done(frame_done0)
    );

    uart_frame_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1)) u_odd (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready1), .tx(tx1), .busy(busy1), .frame_done(frame_done1)
    );

    // Reference line image: start 0, data LSB first, parity from a ones count, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] d, input int odd);
        int          ones;
        logic [10:0] f;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = d[i];
            if (d[i]) ones++;
        end
        f[9]  = ((ones + odd) % 2) == 1;
        f[10] = 1'b1;
        return f;
    endfunction

    // Present one byte for a single clock edge.
    task automatic start_byte(input logic [7:0] d);
        @(negedge clock);
        data_in    = d;
        data_valid = 1'b1;
        @(posedge clock);
        #1 data_valid = 1'b0;
    endtask

    // Sample both lines once per cycle for a whole frame, optionally scrambling inputs.
    task automatic capture(input bit scramble, output logic [10:0] bits0, output logic [10:0] bits1,
                           output bit stable, output bit busy_ok, output int done_at, output int done_cnt);
        int idx;
        stable   = 1'b1;
        busy_ok  = 1'b1;
        done_at  = -1;
        done_cnt = 0;
        bits0    = '0;
        bits1    = '0;
        for (int k = 1; k <= FRAME_CYCLES; k++) begin
            @(negedge clock);
            idx = (k - 1) / CPB;
            if ((k - 1) % CPB == 0) begin
                bits0[idx] = tx0;
                bits1[idx] = tx1;
            end else if (tx0 !== bits0[idx] || tx1 !== bits1[idx]) begin
                stable = 1'b0;
            end
            if (busy0 !== 1'b1 || data_ready0 !== 1'b0 || busy1 !== 1'b1 || data_ready1 !== 1'b0)
                busy_ok = 1'b0;
            if (frame_done1 !== frame_done0) busy_ok = 1'b0;
            if (frame_done0 === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (scramble) begin
                data_valid = 1'($urandom_range(0, 1));
                data_in    = 8'($urandom);
            end
        end
        if (scramble) data_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        data_valid = 1'b0;
        data_in    = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (tx0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b expected 1", tx0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy0); end
        checks++; if (data_ready0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", data_ready0); end
        checks++; if (frame_done0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", frame_done0); end
        reset = 1'b0;
    endtask

    task automatic test_frame_55();
        logic [10:0] b0, b1;
        bit          stable, busy_ok;
        int          done_at, done_cnt;
        start_byte(8'h55);
        capture(1'b0, b0, b1, stable, busy_ok, done_at, done_cnt);
        checks++; if (b0 !== 11'h4AA) begin errors++; $display("[TB] FAIL f55_bits: got %b expected %b", b0, 11'h4AA); end
        checks++; if (!stable) begin errors++; $display("[TB] FAIL f55_bit_hold: got unstable expected %0d-cycle bits", CPB); end
        checks++; if (!busy_ok) begin errors++; $display("[TB] FAIL f55_busy: got busy/ready wrong during frame expected busy=1 ready=0"); end
        checks++; if (done_at != 44 || done_cnt != 1) begin errors++; $display("[TB] FAIL f55_done: got cycle %0d count %0d expected cycle 44 count 1", done_at, done_cnt); end
        @(negedge clock);
        checks++; if (data_ready0 !== 1'b1 || tx0 !== 1'b1 || busy0 !== 1'b0 || frame_done0 !== 1'b0) begin
            errors++; $display("[TB] FAIL f55_cycle45: got ready=%b tx=%b busy=%b done=%b expected 1 1 0 0", data_ready0, tx0, busy0, frame_done0);
        end
    endtask

    task automatic test_parity();
        logic [10:0] b0, b1;
        logic [7:0]  bytes [2];
        logic        even_par [2];
        bit          stable, busy_ok;
        int          done_at, done_cnt;
        bytes[0] = 8'h01; even_par[0] = 1'b1;
        bytes[1] = 8'hFF; even_par[1] = 1'b0;
        for (int n = 0; n < 2; n++) begin
            start_byte(bytes[n]);
            capture(1'b0, b0, b1, stable, busy_ok, done_at, done_cnt);
            checks++; if (b0[9] !== even_par[n]) begin errors++; $display("[TB] FAIL parity_even_%h: got %b expected %b", bytes[n], b0[9], even_par[n]); end
            checks++; if (b1[9] !== ~even_par[n]) begin errors++; $display("[TB] FAIL parity_odd_%h: got %b expected %b", bytes[n], b1[9], ~even_par[n]); end
            checks++; if (b0 !== model_frame(bytes[n], 0) || b1 !== model_frame(bytes[n], 1)) begin
                errors++; $display("[TB] FAIL parity_frame_%h: got %b/%b expected %b/%b", bytes[n], b0, b1, model_frame(bytes[n], 0), model_frame(bytes[n], 1));
            end
            @(negedge clock);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] b0, b1;
        bit          stable, busy_ok, quiet;
        int          done_at, done_cnt;
        @(negedge clock);
        data_in    = 8'hA5;
        data_valid = 1'b1;
        @(posedge clock);
        #1 data_in = 8'h3C;
        capture(1'b0, b0, b1, stable, busy_ok, done_at, done_cnt);
        checks++; if (b0 !== model_frame(8'hA5, 0) || !stable) begin errors++; $display("[TB] FAIL b2b_first: got %b stable=%0d expected %b", b0, stable, model_frame(8'hA5, 0)); end
        @(negedge clock);
        checks++; if (tx0 !== 1'b1 || data_ready0 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_gap: got tx=%b ready=%b expected 1 1", tx0, data_ready0); end
        @(posedge clock);
        #1 data_valid = 1'b0;
        capture(1'b0, b0, b1, stable, busy_ok, done_at, done_cnt);
        checks++; if (b0 !== model_frame(8'h3C, 0) || !stable || !busy_ok) begin errors++; $display("[TB] FAIL b2b_second: got %b stable=%0d busy_ok=%0d expected %b", b0, stable, busy_ok, model_frame(8'h3C, 0)); end
        checks++; if (done_at != 44 || done_cnt != 1) begin errors++; $display("[TB] FAIL b2b_done: got cycle %0d count %0d expected 44 1", done_at, done_cnt); end
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (tx0 !== 1'b1 || busy0 !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("[TB] FAIL b2b_no_third: got activity expected idle line"); end
    endtask

    task automatic test_ignore_during_send();
        logic [10:0] b0, b1;
        bit          stable, busy_ok, quiet;
        int          done_at, done_cnt;
        start_byte(8'h81);
        capture(1'b1, b0, b1, stable, busy_ok, done_at, done_cnt);
        checks++; if (b0 !== model_frame(8'h81, 0) || b1 !== model_frame(8'h81, 1) || !stable) begin
            errors++; $display("[TB] FAIL ignore_frame: got %b/%b stable=%0d expected %b/%b", b0, b1, stable, model_frame(8'h81, 0), model_frame(8'h81, 1));
        end
        quiet = 1'b1;
        repeat (15) begin
            @(negedge clock);
            if (tx0 !== 1'b1 || busy0 !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("[TB] FAIL ignore_no_extra: got activity expected idle line"); end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] b0, b1;
        bit          stable, busy_ok;
        int          done_at, done_cnt;
        start_byte(8'($urandom));
        repeat (17) @(negedge clock);
        checks++; if (busy0 !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy_before: got %b expected 1", busy0); end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (tx0 !== 1'b1 || busy0 !== 1'b0 || data_ready0 !== 1'b1 || frame_done0 !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_after: got tx=%b busy=%b ready=%b done=%b expected 1 0 1 0", tx0, busy0, data_ready0, frame_done0);
        end
        reset = 1'b0;
        start_byte(8'h0F);
        capture(1'b0, b0, b1, stable, busy_ok, done_at, done_cnt);
        checks++; if (b0 !== model_frame(8'h0F, 0) || !stable || done_at != 44) begin
            errors++; $display("[TB] FAIL midrst_resend: got %b stable=%0d done=%0d expected %b done=44", b0, stable, done_at, model_frame(8'h0F, 0));
        end
        @(negedge clock);
    endtask

    task automatic test_reset_with_valid();
        bit quiet;
        @(negedge clock);
        reset      = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'($urandom);
        @(negedge clock);
        reset      = 1'b0;
        data_valid = 1'b0;
        checks++; if (busy0 !== 1'b0 || tx0 !== 1'b1 || data_ready0 !== 1'b1) begin
            errors++; $display("[TB] FAIL rstvalid_state: got busy=%b tx=%b ready=%b expected 0 1 1", busy0, tx0, data_ready0);
        end
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clock);
            if (tx0 !== 1'b1 || busy0 !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("[TB] FAIL rstvalid_no_frame: got activity expected idle line"); end
    endtask

    task automatic test_random_bytes();
        logic [10:0] b0, b1;
        logic [7:0]  d;
        bit          stable, busy_ok;
        int          done_at, done_cnt;
        for (int n = 0; n < 8; n++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clock);
            start_byte(d);
            capture(1'b0, b0, b1, stable, busy_ok, done_at, done_cnt);
            checks++; if (b0 !== model_frame(d, 0) || b1 !== model_frame(d, 1)) begin
                errors++; $display("[TB] FAIL random_frame_%h: got %b/%b expected %b/%b", d, b0, b1, model_frame(d, 0), model_frame(d, 1));
            end
            checks++; if (!stable || !busy_ok || done_at != 44 || done_cnt != 1) begin
                errors++; $display("[TB] FAIL random_timing_%h: got stable=%0d busy_ok=%0d done=%0d count=%0d expected 1 1 44 1", d, stable, busy_ok, done_at, done_cnt);
            end
            @(negedge clock);
        end
    endtask

    // Safety net so a stuck design can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_frame_55();
        test_parity();
        test_back_to_back();
        test_ignore_during_send();
        test_reset_mid_frame();
        test_reset_with_valid();
        test_random_bytes();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 Port clock  input  1  single system clock; all logic on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port data_in  input  8  byte to transmit; sampled only on the accept cycle.
REQ-006 Port data_valid  input  1  upstream asserts while data_in holds a byte.
REQ-007 Port data_ready  output  1  high when the block can accept a byte this cycle.
REQ-008 Port tx  output  1  serial line, idle high.
REQ-009 Port busy  output  1  high while a frame is on the line.
REQ-010 Port frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Function
REQ-011 Frame SHALL be 11 bits, sent in order: start (0), data[0]..data[7] (LSB first), parity, stop (1).
REQ-012 Parity bit SHALL equal XOR of data_in[7:0] XOR PARITY_ODD.
REQ-013 FSM SHALL have two states: IDLE and SEND.
REQ-014 IDLE: tx=1, busy=0, data_ready=1; transfer occurs when data_valid && data_ready on a rising edge.
REQ-015 On transfer: latch the 11-bit frame into an internal shift register, load the bit counter with 0, load the baud counter with CLKS_PER_BIT-1, and enter SEND.
REQ-016 tx SHALL show the start bit from the cycle after the accept edge: latency is 1 cycle.
REQ-017 SEND: data_ready=0, busy=1; each bit SHALL be held for exactly CLKS_PER_BIT cycles.
REQ-018 On baud counter reaching 0: shift the frame right by one and increment the bit counter; reload the baud counter with CLKS_PER_BIT-1.
REQ-019 When the counter reaches 0 on bit index 10 (stop): pulse frame_done for that cycle and return to IDLE.
REQ-020 Whole frame SHALL occupy exactly 11*CLKS_PER_BIT cycles of tx.
REQ-021 Back-to-back: a byte accepted in the first IDLE cycle after a frame SHALL start its start bit one cycle later.
REQ-022 This gives a minimum of 1 idle-high cycle between frames.
REQ-023 data_valid while data_ready=0 SHALL be ignored; data_in changes during SEND SHALL NOT affect the frame in flight.
REQ-024 The baud counter SHALL be 16 bits wide; the bit counter SHALL be 4 bits wide and never exceed 10.
REQ-025 All outputs SHALL be registered; tx SHALL be glitch-free.

Reset
REQ-026 When reset=1 on a rising edge, the block SHALL enter IDLE, including mid-frame; the frame in flight SHALL be abandoned.
REQ-027 Values on that edge: tx=1, busy=0, data_ready=1, frame_done=0; counters and shift register cleared.
REQ-028 reset SHALL take priority over a simultaneous data_valid; no byte is accepted on a reset cycle.

Structure
REQ-029 A shared UART constants package/include SHALL hold: FRAME_BITS=11, DATA_BITS=8, START_BIT=0, STOP_BIT=1, the default CLKS_PER_BIT, and state encodings IDLE=1'b0, SEND=1'b1.
REQ-030 One sub-module, uart_baud_gen, SHALL hold the reloadable baud counter; it outputs a one-cycle bit_tick and has a restart input.
REQ-031 The FSM, shift register and bit counter SHALL stay in uart_frame_tx.

Verification (CLKS_PER_BIT=4, PARITY_ODD=0 unless stated)
REQ-032 Send 0x55: tx SHALL read 0,1,0,1,0,1,0,1,0,0,1, each bit held 4 cycles; frame_done pulses at cycle 44 after accept; data_ready returns high on cycle 45.
REQ-033 Send 0x01, then 0xFF: parity bits SHALL be 1 and 0; with PARITY_ODD=1 they SHALL be 0 and 1.
REQ-034 Keep data_valid high with bytes 0xA5 then 0x3C: two frames SHALL be sent with exactly 1 idle-high cycle between them; no byte is lost or duplicated.
REQ-035 Toggle data_valid and data_in randomly during a 0x81 frame: the frame on tx SHALL be unchanged and no extra frame SHALL follow.
REQ-036 Assert reset for 1 cycle at cycle 17 of a frame: tx=1, busy=0 and data_ready=1 on the next cycle; a new byte 0x0F SHALL then send correctly.
REQ-037 Assert reset together with data_valid: no frame SHALL start.
